// File: rtl/test_seq_pkg.sv
// Shared types and constants for the board self-test sequencer.
package test_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Test slot numbering; bit positions in test_init/test_done/result/...
  localparam int TEST_SD    = 0;
  localparam int TEST_FLASH = 1;
  localparam int TEST_SDRAM = 2;
  localparam int NUM_TESTS  = 3;

  // Index of the final test in the sequence.
  localparam logic [1:0] LAST_IDX = 2'(TEST_SDRAM);

endpackage

// File: rtl/btn_debouncer.sv
// User button conditioning: 2-FF synchronizer followed by a stability
// counter. Emits a one-cycle pulse on the cycle the debounced level rises.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 70_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_differ;
  logic          w_settled;

  // Raw level differs from the accepted level; settled once it has differed long enough.
  assign w_differ  = r_sync[1] ^ r_stable;
  assign w_settled = w_differ && (r_cnt == LP_LAST);

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_btn};
  end

  // Count consecutive cycles of a changed level; accept it once stable, pulse on a rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
        r_press  <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/test_sequencer.sv
// Runs the SD, flash and SDRAM self-tests one after another with a per-test
// timeout, latches pass/timeout flags and requests the text window be hidden
// when everything passed. Restarts on a debounced button press once finished.
// Build option: TEST_SEQ_STOP_ON_FAIL_EN ends the sequence at the first
// failing or timed-out test.
module test_sequencer
  import test_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = 7_000_000,
  parameter int DEBOUNCE_CYCLES = 70_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_user,
  output logic [NUM_TESTS-1:0] test_init,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_pass,
  output logic [NUM_TESTS-1:0] progress,
  output logic [NUM_TESTS-1:0] result,
  output logic [NUM_TESTS-1:0] timeout,
  output logic                 all_done,
  output logic                 hidetextwindow
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef TEST_SEQ_STOP_ON_FAIL_EN
  localparam bit LP_STOP_ON_FAIL = 1'b1;
`else
  localparam bit LP_STOP_ON_FAIL = 1'b0;
`endif

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_idx;
  logic [TW-1:0]        r_cnt;
  logic [NUM_TESTS-1:0] r_progress;
  logic [NUM_TESTS-1:0] r_result;
  logic [NUM_TESTS-1:0] r_timeout;
  logic [NUM_TESTS-1:0] r_ran;
  logic [NUM_TESTS-1:0] w_init;
  logic                 w_all_done;
  logic                 w_hide;
  logic                 w_press;
  logic                 w_done_hit;
  logic                 w_pass_hit;
  logic                 w_to_hit;

  btn_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_btn   (btn_user),
    .o_press (w_press)
  );

  // Only the engine currently selected by r_idx is listened to.
  assign w_done_hit = test_done[r_idx];
  assign w_pass_hit = test_pass[r_idx];
  assign w_to_hit   = (r_cnt == LP_TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; a done pulse takes priority over a coincident timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done_hit)
          w_next = (LP_STOP_ON_FAIL && !w_pass_hit) ? ST_DONE : ST_NEXT;
        else if (w_to_hit)
          w_next = LP_STOP_ON_FAIL ? ST_DONE : ST_NEXT;
      end
      ST_NEXT:   w_next = (r_idx == LAST_IDX) ? ST_DONE : ST_LAUNCH;
      ST_DONE:   w_next = w_press ? ST_LAUNCH : ST_DONE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Moore outputs: init strobe in LAUNCH, completion flags in DONE.
  always_comb begin
    w_init = '0;
    if (r_state == ST_LAUNCH) w_init[r_idx] = 1'b1;
    w_all_done = (r_state == ST_DONE);
    w_hide     = w_all_done && (r_result == r_ran);
  end

  // Index, timeout counter and latched per-test flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= 2'(TEST_SD);
      r_cnt      <= '0;
      r_progress <= '0;
      r_result   <= '0;
      r_timeout  <= '0;
      r_ran      <= '0;
    end else begin
      case (r_state)
        ST_LAUNCH: begin
          r_cnt             <= '0;
          r_progress[r_idx] <= 1'b1;
          r_ran[r_idx]      <= 1'b1;
        end
        ST_WAIT: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
          if (w_done_hit) begin
            r_result[r_idx]   <= w_pass_hit;
            r_progress[r_idx] <= 1'b0;
          end else if (w_to_hit) begin
            r_timeout[r_idx]  <= 1'b1;
            r_result[r_idx]   <= 1'b0;
            r_progress[r_idx] <= 1'b0;
          end
        end
        ST_NEXT: begin
          if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
        end
        ST_DONE: begin
          if (w_press) begin
            r_idx     <= 2'(TEST_SD);
            r_result  <= '0;
            r_timeout <= '0;
            r_ran     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign test_init      = w_init;
  assign progress       = r_progress;
  assign result         = r_result;
  assign timeout        = r_timeout;
  assign all_done       = w_all_done;
  assign hidetextwindow = w_hide;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: table of scenarios plus randomized scenarios,
// each scored against a sequence-level reference model.
module tb_test_sequencer;

  localparam int T      = 100;
  localparam int DEB    = 8;
  localparam int BUDGET = 800;
  localparam int NTBL   = 6;
  localparam int NRND   = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_user = 1'b0;
  logic [2:0] test_init;
  logic [2:0] test_done = 3'b000;
  logic [2:0] test_pass = 3'b000;
  logic [2:0] progress;
  logic [2:0] result;
  logic [2:0] timeout;
  logic       all_done;
  logic       hidetextwindow;

  int vectors     = 0;
  int miscompares = 0;

  test_sequencer #(
    .TIMEOUT_CYCLES  (T),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_user       (btn_user),
    .test_init      (test_init),
    .test_done      (test_done),
    .test_pass      (test_pass),
    .progress       (progress),
    .result         (result),
    .timeout        (timeout),
    .all_done       (all_done),
    .hidetextwindow (hidetextwindow)
  );

  // Clock
  always #5 clk = ~clk;

  // One scenario: done delay per engine (0 = never answers), pass flags,
  // optional mid-run button press, optional reset during SDRAM, expectations.
  typedef struct {
    int         d0;
    int         d1;
    int         d2;
    logic [2:0] p;
    int         btn_at;
    int         rst_after;
    logic [2:0] exp_res;
    logic [2:0] exp_to;
    logic       exp_hide;
    int         exp_n;
  } vec_t;

  vec_t tbl[NTBL];

  // Reference model outputs
  int         m_eff[3];
  logic [2:0] m_res;
  logic [2:0] m_to;
  logic       m_hide;
  int         m_n;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Sequence-level model: a test passes on time if it answers within T cycles
  // of its init (answer on cycle T still counts); otherwise it times out.
  task automatic model(input int d0, input int d1, input int d2, input logic [2:0] p);
    int  d[3];
    bit  stop;
    d[0] = d0; d[1] = d1; d[2] = d2;
    m_res = 3'b000; m_to = 3'b000; m_n = 0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_eff[i] = T;
      if (!stop) begin
        m_n++;
        if (d[i] >= 1 && d[i] <= T) begin
          m_eff[i] = d[i];
          m_res[i] = p[i];
        end else begin
          m_to[i] = 1'b1;
        end
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
        if (!m_res[i]) stop = 1'b1;
`endif
      end
    end
    m_hide = (m_res == 3'b111);
  endtask

  task automatic run(input vec_t v, input int vidx, input bit need_press);
    int         d[3];
    int         init_cyc[3];
    int         fall_cyc[3];
    logic [2:0] init_q[$];
    int         cyc, cur, btn_cnt, press_cyc, stale_cyc;
    bit         started, got_done, rst_done;
    logic [2:0] prev_prog, dv, pv;
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    model(v.d0, v.d1, v.d2, v.p);
    for (int k = 0; k < 3; k++) begin init_cyc[k] = -1; fall_cyc[k] = -1; end
    cyc = 0; cur = 0; btn_cnt = 0; press_cyc = 0; stale_cyc = -1;
    started = 1'b0; got_done = 1'b0; rst_done = 1'b0; prev_prog = 3'b000;
    while (cyc < BUDGET && !got_done) begin
      @(negedge clk); cyc++;
      if (v.rst_after > 0 && !rst_done && init_cyc[2] >= 0 && cyc - init_cyc[2] == v.rst_after) begin
        rst = 1'b1; test_done = 3'b000;
        @(negedge clk); cyc++;
        check("reset_clear", vidx, {test_init, progress, result, timeout, all_done, hidetextwindow}, 0);
        rst = 1'b0; rst_done = 1'b1; started = 1'b0; init_q.delete();
        for (int k = 0; k < 3; k++) begin init_cyc[k] = -1; fall_cyc[k] = -1; end
        prev_prog = 3'b000; stale_cyc = cyc + 3;
        continue;
      end
      if (test_init != 3'b000) begin
        init_q.push_back(test_init);
        cur = test_init[0] ? 0 : (test_init[1] ? 1 : 2);
        init_cyc[cur] = cyc;
        if (!started && need_press && !rst_done) begin
          check("press_latency", vidx, cyc - press_cyc, 2 + DEB + 1);
          check("restart_clear", vidx, {result, timeout, all_done, hidetextwindow}, 0);
        end
        started = 1'b1;
      end
      for (int k = 0; k < 3; k++)
        if (prev_prog[k] && !progress[k]) fall_cyc[k] = cyc;
      prev_prog = progress;
      if (started && all_done) begin
        got_done = 1'b1;
        break;
      end
      dv = 3'b000;
      pv = 3'($urandom);
      for (int k = 0; k < 3; k++)
        if (k != cur && $urandom_range(0, 7) == 0) dv[k] = 1'b1;
      if (started && init_cyc[cur] >= 0 && d[cur] != 0 && cyc - init_cyc[cur] == d[cur]) begin
        dv[cur] = 1'b1;
        pv[cur] = v.p[cur];
      end
      if (cyc == stale_cyc) begin dv[2] = 1'b1; pv[2] = 1'b1; end
      test_done = dv;
      test_pass = pv;
      if (need_press && cyc == 1) begin btn_cnt = 20; press_cyc = cyc; end
      if (v.btn_at > 0 && cyc == v.btn_at) btn_cnt = 20;
      btn_user = (btn_cnt > 0);
      if (btn_cnt > 0) btn_cnt--;
    end
    test_done = 3'b000;
    check("all_done_seen", vidx, 32'(got_done), 1);
    check("result", vidx, result, v.exp_res);
    check("timeout", vidx, timeout, v.exp_to);
    check("hidetextwindow", vidx, hidetextwindow, v.exp_hide);
    check("init_count", vidx, init_q.size(), v.exp_n);
    for (int k = 0; k < init_q.size() && k < 3; k++) begin
      logic [2:0] one;
      one = 3'b001 << k;
      check("init_order", vidx * 10 + k, init_q[k], one);
    end
    for (int k = 0; k < v.exp_n && k < 3; k++) begin
      if (init_cyc[k] >= 0) begin
        check("progress_fall", vidx * 10 + k, fall_cyc[k] - init_cyc[k], m_eff[k] + 1);
        if (k > 0 && init_cyc[k-1] >= 0)
          check("launch_gap", vidx * 10 + k, init_cyc[k] - init_cyc[k-1], m_eff[k-1] + 2);
      end
    end
    while (btn_cnt > 0) begin @(negedge clk); btn_cnt--; end
    btn_user = 1'b0;
    repeat (12) @(negedge clk);
    if (got_done) begin
      btn_user = 1'b1;
      repeat (3) @(negedge clk);
      btn_user = 1'b0;
      repeat (15) @(negedge clk);
      check("glitch_all_done", vidx, all_done, 1);
      check("glitch_result", vidx, result, v.exp_res);
    end
  endtask

  initial begin
    vec_t rv;
    int   r;
    int   dd[3];
    // Table: d0, d1, d2, pass, btn_at, rst_after, exp_res, exp_to, exp_hide, exp_n
    tbl[0] = '{10, 10, 10, 3'b111, 0, 0, 3'b111, 3'b000, 1'b1, 3};   // all pass
`ifdef TEST_SEQ_STOP_ON_FAIL_EN
    tbl[1] = '{10, 0, 10, 3'b111, 0, 0, 3'b001, 3'b010, 1'b0, 2};    // flash silent
    tbl[5] = '{5, 10, 10, 3'b110, 0, 0, 3'b000, 3'b000, 1'b0, 1};    // SD fails
`else
    tbl[1] = '{10, 0, 10, 3'b111, 0, 0, 3'b101, 3'b010, 1'b0, 3};    // flash silent
    tbl[5] = '{5, 10, 10, 3'b110, 0, 0, 3'b110, 3'b000, 1'b0, 3};    // SD fails
`endif
    tbl[2] = '{T, 10, 10, 3'b111, 0, 0, 3'b111, 3'b000, 1'b1, 3};    // done on timeout cycle
    tbl[3] = '{80, 10, 10, 3'b111, 40, 0, 3'b111, 3'b000, 1'b1, 3};  // press during WAIT
    tbl[4] = '{10, 10, 20, 3'b111, 0, 5, 3'b111, 3'b000, 1'b1, 3};   // reset mid-SDRAM

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 0, {test_init, progress, result, timeout, all_done, hidetextwindow}, 0);
    rst = 1'b0;

    for (int i = 0; i < NTBL; i++) run(tbl[i], i, i != 0);

    for (int i = 0; i < NRND; i++) begin
      for (int k = 0; k < 3; k++) begin
        r = $urandom_range(0, 9);
        case (r)
          0:       dd[k] = 0;
          1:       dd[k] = T - 1;
          2:       dd[k] = T;
          3:       dd[k] = T + 1;
          default: dd[k] = $urandom_range(1, 15);
        endcase
      end
      rv.d0 = dd[0]; rv.d1 = dd[1]; rv.d2 = dd[2];
      rv.p = 3'($urandom);
      rv.btn_at = 0; rv.rst_after = 0;
      model(rv.d0, rv.d1, rv.d2, rv.p);
      rv.exp_res = m_res; rv.exp_to = m_to; rv.exp_hide = m_hide; rv.exp_n = m_n;
      run(rv, 100 + i, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
